fp_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle single-precision floating-point adder among N requesters. It takes one add/subtract request at a time and issues it to the adder with a start pulse. It then waits for the adder's done strobe and returns the result and error flag to the requester that won arbitration. It sits between the instruction-side clients (ALU lanes, test harness) and the shared adder datapath.

---
 rtl/fp_add_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sequencer sharing one multi-cycle FP adder
// among N requesters. One operation in flight at a time:
//   IDLE -> ISSUE (gnt + add_start) -> WAIT (for add_done) -> RESP (rsp_valid)
//
// Ports
//   clk, rst          clock, async active-high reset
//   req/req_a/req_b/req_op   per-requester request, operands (32b slices), op
//   gnt               one-hot accept pulse (ISSUE cycle)
//   rsp_valid/rsp_res/rsp_err  one-hot response pulse with result/error
//   add_start/add_a/add_b/add_op  adder issue side (operands held until IDLE)
//   add_done/add_res/add_err      adder completion side
//
// Optional feature: define FP_ADD_ARB_TIMEOUT_EN to abort a WAIT after
// TIMEOUT cycles with result 32'hFFFFFFFF and error set.
module fp_add_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [32*N-1:0]     req_a,
  input  logic [32*N-1:0]     req_b,
  input  logic [N-1:0]        req_op,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        rsp_valid,
  output logic [31:0]         rsp_res,
  output logic                rsp_err,
  output logic                add_start,
  output logic [31:0]         add_a,
  output logic [31:0]         add_b,
  output logic                add_op,
  input  logic                add_done,
  input  logic [31:0]         add_res,
  input  logic                add_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || TIMEOUT < 1) begin : g_param_check
    $error("fp_add_arbiter: N must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [31:0]    a_q, a_d, b_q, b_d;
  logic           op_q, op_d;
  logic [31:0]    res_q, res_d;
  logic           err_q, err_d;
`ifdef FP_ADD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]  cnt_q, cnt_d;
`endif

  // Slot visited at search offset `off` from the pointer, wrapping at N
  // (N need not be a power of two).
  function automatic logic [IW-1:0] rr_slot(input logic [IW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  logic          win_vld;
  logic [IW-1:0] win_idx;

  // Walk offsets from the far end back to 0 so the nearest requester to
  // the pointer is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (req[rr_slot(ptr_q, i)]) begin
        win_vld = 1'b1;
        win_idx = rr_slot(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
`ifdef FP_ADD_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (win_vld) begin
        idx_d   = win_idx;
        a_d     = req_a[32*win_idx +: 32];
        b_d     = req_b[32*win_idx +: 32];
        op_d    = req_op[win_idx];
        state_d = ISSUE;
      end
      ISSUE: begin
`ifdef FP_ADD_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (add_done) begin
          res_d   = add_res;
          err_d   = add_err;
          state_d = RESP;
        end
`ifdef FP_ADD_ARB_TIMEOUT_EN
        // Counter holds completed WAIT cycles; this is WAIT cycle cnt_q+1.
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = 32'hFFFF_FFFF;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        ptr_d   = (idx_q == IW'(N-1)) ? '0 : idx_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef FP_ADD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef FP_ADD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Moore outputs from registered state.
  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    if (state_q == ISSUE) gnt[idx_q]       = 1'b1;
    if (state_q == RESP)  rsp_valid[idx_q] = 1'b1;
  end

  assign add_start = (state_q == ISSUE);
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_op    = op_q;
  assign rsp_res   = res_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
module tb_fp_add_arbiter;
  localparam int N   = 4;
  localparam int LAT = 5;  // adder model: done comes LAT cycles after the start cycle

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req, req_op;
  logic [32*N-1:0]   req_a, req_b;
  logic [N-1:0]      gnt, rsp_valid;
  logic [31:0]       rsp_res, add_a, add_b, add_res;
  logic              rsp_err, add_start, add_op, add_done, add_err;

  fp_add_arbiter #(.N(N), .TIMEOUT(63)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_err(rsp_err),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_op(add_op),
    .add_done(add_done), .add_res(add_res), .add_err(add_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, rsp_cnt = 0;
  int gnt_cyc[$], gnt_idx[$], rsp_cyc[$];
  typedef struct { logic [N-1:0] vec; logic [31:0] res; logic err; } exp_t;
  exp_t sb[$];
  logic [N-1:0] auto_drop;
  bit mdl_en = 1'b1, mdl_err = 1'b0, force_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behaviour of the fake adder: 1.0+2.0 gives 3.0, otherwise integer add/sub
  // so the result is a recognisable function of the routed operands.
  function automatic logic [31:0] f_res(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) return 32'h4040_0000;
    return op ? a - b : a + b;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Adder model
  initial begin
    int cd;
    logic [31:0] ra;
    cd = 0; ra = '0;
    add_done = 1'b0; add_res = '0; add_err = 1'b0;
    forever begin
      @(negedge clk);
      add_done = 1'b0;
      if (rst) cd = 0;
      else begin
        if (force_done) begin add_done = 1'b1; force_done = 1'b0; end
        if (cd > 0) begin
          cd--;
          if (cd == 0 && mdl_en) begin add_done = 1'b1; add_res = ra; add_err = mdl_err; end
        end
        if (add_start) begin cd = LAT; ra = f_res(add_a, add_b, add_op); end
      end
    end
  end

  // Monitor: grant log and response scoreboard
  initial begin
    exp_t e;
    int gi;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("start_eq_gnt", add_start, |gnt);
        if (gnt != 0) begin
          gi = idx_of(gnt);
          chk("gnt_onehot", $onehot(gnt), 1);
          chk("gnt_add_a", add_a, req_a[32*gi +: 32]);
          chk("gnt_add_b", add_b, req_b[32*gi +: 32]);
          chk("gnt_add_op", add_op, req_op[gi]);
          gnt_cyc.push_back(cyc);
          gnt_idx.push_back(gi);
          req = req & ~(gnt & auto_drop);
        end
      end
      if (rsp_valid != 0) begin
        rsp_cnt++;
        rsp_cyc.push_back(cyc);
        if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_vec", rsp_valid, e.vec);
          chk("rsp_res", rsp_res, e.res);
          chk("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  task automatic set_opnd(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[i] = op;
  endtask

  task automatic push_exp(input int i, input logic err);
    exp_t e;
    e.vec = '0; e.vec[i] = 1'b1;
    e.res = f_res(req_a[32*i +: 32], req_b[32*i +: 32], req_op[i]);
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_rsp(input int k, input int budget);
    int target;
    target = rsp_cnt + k;
    for (int c = 0; c < budget && rsp_cnt < target; c++) begin
      @(negedge clk); #1;
    end
    if (rsp_cnt < target) chk("rsp_wait_expired", rsp_cnt, target);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_res"}, rsp_res, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_add_start"}, add_start, 0);
    chk({tag, "_add_a"}, add_a, 0);
    chk({tag, "_add_b"}, add_b, 0);
    chk({tag, "_add_op"}, add_op, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int t0, ng, nr;
    rst = 1'b1; req = '0; req_op = '0; req_a = '0; req_b = '0; auto_drop = '1;
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;

    // Single requester, 1.0 + 2.0
    @(negedge clk); #1;
    set_opnd(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    push_exp(0, 1'b0);
    ng = gnt_cyc.size(); nr = rsp_cyc.size();
    t0 = cyc; req = 4'b0001;
    wait_rsp(1, 50);
    chk("t1_gnt_cycle", gnt_cyc[ng] - t0, 1);
    chk("t1_rsp_cycle", rsp_cyc[nr] - t0, 7);

    // Simultaneous 0 and 1 from reset, then pointer probe with 0,1,2
    do_reset();
    set_opnd(0, 32'h0000_1000, 32'h0000_0234, 1'b0);
    set_opnd(1, 32'h0000_5000, 32'h0000_0111, 1'b1);
    push_exp(0, 1'b0); push_exp(1, 1'b0);
    ng = gnt_cyc.size();
    req = 4'b0011;
    wait_rsp(2, 60);
    chk("t2_order0", gnt_idx[ng], 0);
    chk("t2_order1", gnt_idx[ng+1], 1);
    // ISSUE + LAT WAIT cycles + RESP + IDLE between consecutive grants
    chk("t2_spacing", gnt_cyc[ng+1] - gnt_cyc[ng], LAT + 3);
    set_opnd(2, 32'h1234_0000, 32'h0000_5678, 1'b0);
    push_exp(2, 1'b0); push_exp(0, 1'b0); push_exp(1, 1'b0);
    ng = gnt_cyc.size();
    req = 4'b0111;
    wait_rsp(3, 80);
    chk("t2_ptr_is_2", gnt_idx[ng], 2);

    // All four held: full rotation plus wrap
    do_reset();
    for (int i = 0; i < N; i++) set_opnd(i, 32'h100 * (i + 1), 32'h7 + i, i[0]);
    push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(2, 1'b0); push_exp(3, 1'b0); push_exp(0, 1'b0);
    auto_drop = '0;
    ng = gnt_cyc.size();
    req = 4'b1111;
    wait_rsp(5, 120);
    req = '0;
    auto_drop = '1;
    repeat (4) @(negedge clk);
    #1 chk("t3_gnt_count", gnt_cyc.size() - ng, 5);

    // Adder error propagates
    mdl_err = 1'b1;
    set_opnd(2, 32'hAAAA_0000, 32'h0000_5555, 1'b1);
    push_exp(2, 1'b1);
    req = 4'b0100;
    wait_rsp(1, 50);
    mdl_err = 1'b0;

    // Adder never answers
    mdl_en = 1'b0;
    set_opnd(3, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    ng = gnt_cyc.size(); nr = rsp_cyc.size();
`ifdef FP_ADD_ARB_TIMEOUT_EN
    begin
      exp_t e;
      e.vec = 4'b1000; e.res = 32'hFFFF_FFFF; e.err = 1'b1;
      sb.push_back(e);
    end
    req = 4'b1000;
    wait_rsp(1, 200);
    chk("t5_timeout_cycle", rsp_cyc[nr] - gnt_cyc[ng], 64);
    // Put a fresh operation in WAIT for the reset test
    set_opnd(1, 32'h2222_0000, 32'h0000_3333, 1'b0);
    ng = gnt_cyc.size();
    req = 4'b0010;
    for (int c = 0; c < 20 && gnt_cyc.size() == ng; c++) begin @(negedge clk); #1; end
    chk("t6_gnt_seen", gnt_cyc.size() - ng, 1);
    repeat (3) @(negedge clk);
`else
    t0 = rsp_cnt;
    req = 4'b1000;
    repeat (1000) @(negedge clk);
    #1;
    chk("t5_gnt_seen", gnt_cyc.size() - ng, 1);
    chk("t5_no_rsp", rsp_cnt, t0);
`endif

    // Reset while in WAIT, then a stray add_done
    #1 rst = 1'b1;
    #1 chk_zero("t6_rst");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    force_done = 1'b1;
    t0 = rsp_cnt; ng = gnt_cyc.size();
    repeat (5) @(negedge clk);
    #1 chk("t6_no_rsp", rsp_cnt, t0);
    chk("t6_no_gnt", gnt_cyc.size(), ng);
    mdl_en = 1'b1;
    set_opnd(1, 32'h0000_0042, 32'h0000_0001, 1'b0);
    set_opnd(3, 32'h0000_0099, 32'h0000_0009, 1'b1);
    push_exp(1, 1'b0); push_exp(3, 1'b0);
    req = 4'b1010;
    wait_rsp(2, 60);
    chk("t6_ptr_from_0", gnt_idx[ng], 1);

    repeat (3) @(negedge clk);
    #1 chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
